instr_mem_loader: RTL and testbench

- Program loader: the write side of the instruction memory that the fetch/PC block reads.
- Accepts a byte stream (valid/ready), parses a 16-bit word-count header, then instruction/argument byte pairs.
- Packs each pair into one INSTRUCTION_WIDTH word and drives the instruction-memory write port at sequential addresses from 0.
- Holds the CPU (fetch block and PC) in hold until loading completes.

---
 rtl/instr_mem_loader_if.sv | 24 ++
 rtl/instr_mem_loader.sv | 159 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader uses the slave side; the stream source and memory use the master side.
interface instr_mem_loader_if #(
   parameter int unsigned DATA_WIDTH        = 8,
   parameter int unsigned ADDR_WIDTH        = 12,
   parameter int unsigned INSTRUCTION_WIDTH = 16
);
   logic [DATA_WIDTH-1:0]        IN_DATA;
   logic                         IN_VALID;
   logic                         IN_READY;
   logic                         MEM_WE;
   logic [ADDR_WIDTH-1:0]        MEM_ADDR;
   logic [INSTRUCTION_WIDTH-1:0] MEM_DATA;

   modport master (
      output IN_DATA, IN_VALID,
      input  IN_READY, MEM_WE, MEM_ADDR, MEM_DATA
   );

   modport slave (
      input  IN_DATA, IN_VALID,
      output IN_READY, MEM_WE, MEM_ADDR, MEM_DATA
   );
endinterface

// File: rtl/instr_mem_loader.sv
// Program loader: parses a 16-bit word-count header, then packs instr/arg byte
// pairs into instruction-memory writes at sequential addresses, holding the CPU until done.
module instr_mem_loader #(
   parameter int unsigned DATA_WIDTH        = 8,
   parameter int unsigned ADDR_WIDTH        = 12,
   parameter int unsigned INSTRUCTION_WIDTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              START,
   instr_mem_loader_if.slave bus,
   output logic              CPU_HOLD,
   output logic              LOAD_DONE,
   output logic              LOAD_ERR
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_GET_INSTR, S_GET_ARG, S_WRITE, S_DONE, S_ERR
   } state_t;

   localparam logic [16:0]           MAX_WORDS = 17'd1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   state_t                       r_state, w_state_nxt;
   logic [15:0]                  r_len, w_len_nxt;
   logic [16:0]                  r_count, w_count_nxt;
   logic [DATA_WIDTH-1:0]        r_instr, w_instr_nxt;
   logic [ADDR_WIDTH-1:0]        r_addr, w_addr_nxt;
   logic [INSTRUCTION_WIDTH-1:0] r_data, w_data_nxt;
   logic                         r_we, w_we_nxt;
   logic                         r_in_ready, w_in_ready_nxt;
   logic                         r_cpu_hold, w_cpu_hold_nxt;
   logic                         r_load_done, w_load_done_nxt;
   logic                         r_load_err, w_load_err_nxt;

   logic                         w_accept;
   logic [7:0]                   w_hdr_byte;
   logic [15:0]                  w_len_full;
   logic [16:0]                  w_cnt_inc;

   assign w_accept   = bus.IN_VALID & r_in_ready;
   assign w_hdr_byte = 8'(bus.IN_DATA);
   assign w_len_full = {r_len[15:8], w_hdr_byte};
   assign w_cnt_inc  = r_count + 17'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_count     <= '0;
         r_instr     <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_we        <= 1'b0;
         r_in_ready  <= 1'b0;
         r_cpu_hold  <= 1'b1;
         r_load_done <= 1'b0;
         r_load_err  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_len       <= w_len_nxt;
         r_count     <= w_count_nxt;
         r_instr     <= w_instr_nxt;
         r_addr      <= w_addr_nxt;
         r_data      <= w_data_nxt;
         r_we        <= w_we_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_cpu_hold  <= w_cpu_hold_nxt;
         r_load_done <= w_load_done_nxt;
         r_load_err  <= w_load_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: if (START) w_state_nxt = S_LEN_HI;
         S_LEN_HI:    if (w_accept) w_state_nxt = S_LEN_LO;
         S_LEN_LO: begin
            if (w_accept) begin
               // 17-bit compare so a full 2**ADDR_WIDTH load is legal but one more is not
               if (w_len_full == 16'd0)                 w_state_nxt = S_DONE;
               else if ({1'b0, w_len_full} > MAX_WORDS) w_state_nxt = S_ERR;
               else                                     w_state_nxt = S_GET_INSTR;
            end
         end
         S_GET_INSTR: if (w_accept) w_state_nxt = S_GET_ARG;
         S_GET_ARG:   if (w_accept) w_state_nxt = S_WRITE;
         S_WRITE: begin
            if (w_cnt_inc == {1'b0, r_len}) w_state_nxt = S_DONE;
            else                            w_state_nxt = S_GET_INSTR;
         end
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_len_nxt       = r_len;
      w_count_nxt     = r_count;
      w_instr_nxt     = r_instr;
      w_addr_nxt      = r_addr;
      w_data_nxt      = r_data;
      w_we_nxt        = 1'b0;
      w_cpu_hold_nxt  = r_cpu_hold;
      w_load_done_nxt = r_load_done;
      w_load_err_nxt  = r_load_err;
      w_in_ready_nxt  = (w_state_nxt == S_LEN_HI) || (w_state_nxt == S_LEN_LO) ||
                        (w_state_nxt == S_GET_INSTR) || (w_state_nxt == S_GET_ARG);
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (START) begin
               w_cpu_hold_nxt  = 1'b1;
               w_load_done_nxt = 1'b0;
               w_load_err_nxt  = 1'b0;
            end
         end
         S_LEN_HI: if (w_accept) w_len_nxt = {w_hdr_byte, r_len[7:0]};
         S_LEN_LO: begin
            if (w_accept) begin
               w_len_nxt   = w_len_full;
               w_addr_nxt  = '0;
               w_count_nxt = '0;
               if (w_state_nxt == S_DONE) begin
                  w_cpu_hold_nxt  = 1'b0;
                  w_load_done_nxt = 1'b1;
               end
               if (w_state_nxt == S_ERR) w_load_err_nxt = 1'b1;
            end
         end
         S_GET_INSTR: if (w_accept) w_instr_nxt = bus.IN_DATA;
         S_GET_ARG: begin
            if (w_accept) begin
               w_data_nxt = {r_instr, bus.IN_DATA};
               w_we_nxt   = 1'b1;
            end
         end
         S_WRITE: begin
            w_count_nxt = w_cnt_inc;
            // Last word keeps its address, so a full-memory load never wraps
            if (w_state_nxt == S_DONE) begin
               w_cpu_hold_nxt  = 1'b0;
               w_load_done_nxt = 1'b1;
            end else begin
               w_addr_nxt = r_addr + ADDR_ONE;
            end
         end
         default: ;
      endcase
   end

   assign bus.IN_READY = r_in_ready;
   assign bus.MEM_WE   = r_we;
   assign bus.MEM_ADDR = r_addr;
   assign bus.MEM_DATA = r_data;
   assign CPU_HOLD     = r_cpu_hold;
   assign LOAD_DONE    = r_load_done;
   assign LOAD_ERR     = r_load_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: header parsing, packing, error path,
// full-memory load, random stalls and asynchronous reset mid-load.
module tb_instr_mem_loader;

   logic clk = 1'b0;
   logic reset;
   logic START;
   logic CPU_HOLD, LOAD_DONE, LOAD_ERR;

   int checks = 0;
   int errors = 0;

   logic [11:0] wq_addr[$];
   logic [15:0] wq_data[$];
   int          rdy_in_write = 0;

   instr_mem_loader_if #(
      .DATA_WIDTH(8), .ADDR_WIDTH(12), .INSTRUCTION_WIDTH(16)
   ) bus ();

   instr_mem_loader #(
      .DATA_WIDTH(8), .ADDR_WIDTH(12), .INSTRUCTION_WIDTH(16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .START     (START),
      .bus       (bus),
      .CPU_HOLD  (CPU_HOLD),
      .LOAD_DONE (LOAD_DONE),
      .LOAD_ERR  (LOAD_ERR)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset && bus.MEM_WE) begin
         wq_addr.push_back(bus.MEM_ADDR);
         wq_data.push_back(bus.MEM_DATA);
         if (bus.IN_READY) rdy_in_write++;
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit stall);
      int  n = 0;
      bit  done = 0;
      logic rdy;
      while (!done && n < 200) begin
         @(negedge clk);
         if (stall && $urandom_range(0, 1) == 0) begin
            bus.IN_VALID = 1'b0;
            bus.IN_DATA  = 8'hxx;
            @(posedge clk);
         end else begin
            bus.IN_DATA  = b;
            bus.IN_VALID = 1'b1;
            rdy = bus.IN_READY;
            @(posedge clk);
            if (rdy) done = 1;
         end
         n++;
      end
      #1 bus.IN_VALID = 1'b0;
      if (!done) begin
         errors++;
         $display("FAIL send_byte timeout: byte %h not accepted, required acceptance within 200 cycles", b);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      START = 1'b1;
      @(posedge clk);
      #1 START = 1'b0;
   endtask

   task automatic clear_q();
      wq_addr.delete();
      wq_data.delete();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.IN_READY); end
      checks++; if (bus.MEM_WE !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", bus.MEM_WE); end
      checks++; if (bus.MEM_ADDR !== 12'h000) begin errors++; $display("FAIL reset_mem_addr: got %h want 000", bus.MEM_ADDR); end
      checks++; if (bus.MEM_DATA !== 16'h0000) begin errors++; $display("FAIL reset_mem_data: got %h want 0000", bus.MEM_DATA); end
      checks++; if (CPU_HOLD !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold: got %b want 1", CPU_HOLD); end
      checks++; if (LOAD_DONE !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b want 0", LOAD_DONE); end
      checks++; if (LOAD_ERR !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b want 0", LOAD_ERR); end
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %b want 0", bus.IN_READY); end
   endtask

   task automatic test_basic();
      clear_q();
      pulse_start();
      checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL basic_ready_after_start: got %b want 1", bus.IN_READY); end
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      checks++; if (bus.MEM_WE !== 1'b1 || bus.MEM_ADDR !== 12'h000 || bus.MEM_DATA !== 16'h1122) begin
         errors++; $display("FAIL basic_write0_latency: got we=%b addr=%h data=%h want we=1 addr=000 data=1122", bus.MEM_WE, bus.MEM_ADDR, bus.MEM_DATA);
      end
      checks++; if (bus.IN_READY !== 1'b0 || CPU_HOLD !== 1'b1) begin
         errors++; $display("FAIL basic_write_cycle_flags: got ready=%b hold=%b want ready=0 hold=1", bus.IN_READY, CPU_HOLD);
      end
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      @(posedge clk); #1;
      checks++; if (wq_addr.size() !== 2) begin errors++; $display("FAIL basic_write_count: got %0d want 2", wq_addr.size()); end
      else begin
         checks++; if (wq_addr[0] !== 12'h000 || wq_data[0] !== 16'h1122) begin errors++; $display("FAIL basic_w0: got %h/%h want 000/1122", wq_addr[0], wq_data[0]); end
         checks++; if (wq_addr[1] !== 12'h001 || wq_data[1] !== 16'h3344) begin errors++; $display("FAIL basic_w1: got %h/%h want 001/3344", wq_addr[1], wq_data[1]); end
      end
      checks++; if (LOAD_DONE !== 1'b1 || CPU_HOLD !== 1'b0 || LOAD_ERR !== 1'b0) begin
         errors++; $display("FAIL basic_done: got done=%b hold=%b err=%b want 1/0/0", LOAD_DONE, CPU_HOLD, LOAD_ERR);
      end
   endtask

   task automatic test_zero_len();
      clear_q();
      pulse_start();
      checks++; if (CPU_HOLD !== 1'b1 || LOAD_DONE !== 1'b0) begin
         errors++; $display("FAIL zero_restart_flags: got hold=%b done=%b want 1/0", CPU_HOLD, LOAD_DONE);
      end
      send_byte(8'h00, 0);
      checks++; if (CPU_HOLD !== 1'b1) begin errors++; $display("FAIL zero_hold_mid_header: got %b want 1", CPU_HOLD); end
      send_byte(8'h00, 0);
      checks++; if (CPU_HOLD !== 1'b0 || LOAD_DONE !== 1'b1) begin
         errors++; $display("FAIL zero_done: got hold=%b done=%b want 0/1", CPU_HOLD, LOAD_DONE);
      end
      repeat (3) @(posedge clk); #1;
      checks++; if (wq_addr.size() !== 0) begin errors++; $display("FAIL zero_no_writes: got %0d writes want 0", wq_addr.size()); end
   endtask

   task automatic test_error();
      clear_q();
      pulse_start();
      send_byte(8'h10, 0);
      send_byte(8'h01, 0);
      checks++; if (LOAD_ERR !== 1'b1 || CPU_HOLD !== 1'b1 || bus.IN_READY !== 1'b0 || LOAD_DONE !== 1'b0) begin
         errors++; $display("FAIL err_flags: got err=%b hold=%b ready=%b done=%b want 1/1/0/0", LOAD_ERR, CPU_HOLD, bus.IN_READY, LOAD_DONE);
      end
      repeat (3) @(posedge clk); #1;
      checks++; if (wq_addr.size() !== 0 || bus.IN_READY !== 1'b0) begin
         errors++; $display("FAIL err_idle: got writes=%0d ready=%b want 0/0", wq_addr.size(), bus.IN_READY);
      end
      pulse_start();
      checks++; if (LOAD_ERR !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", LOAD_ERR); end
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      @(posedge clk); #1;
      checks++; if (wq_addr.size() !== 1) begin errors++; $display("FAIL err_recover_count: got %0d want 1", wq_addr.size()); end
      else begin
         checks++; if (wq_addr[0] !== 12'h000 || wq_data[0] !== 16'hAABB) begin errors++; $display("FAIL err_recover_w0: got %h/%h want 000/AABB", wq_addr[0], wq_data[0]); end
      end
      checks++; if (LOAD_DONE !== 1'b1 || LOAD_ERR !== 1'b0) begin
         errors++; $display("FAIL err_recover_done: got done=%b err=%b want 1/0", LOAD_DONE, LOAD_ERR);
      end
   endtask

   task automatic test_full_memory();
      int bad = 0;
      logic [11:0] iv;
      logic [15:0] exp_d;
      clear_q();
      pulse_start();
      send_byte(8'h10, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 4096; i++) begin
         iv = 12'(i);
         send_byte(iv[7:0] ^ 8'h5A, 0);
         send_byte(iv[11:4], 0);
      end
      @(posedge clk); #1;
      checks++; if (wq_addr.size() !== 4096) begin errors++; $display("FAIL full_write_count: got %0d want 4096", wq_addr.size()); end
      else begin
         for (int i = 0; i < 4096; i++) begin
            iv = 12'(i);
            exp_d = {iv[7:0] ^ 8'h5A, iv[11:4]};
            if (wq_addr[i] !== iv || wq_data[i] !== exp_d) bad++;
         end
         checks++; if (bad !== 0) begin errors++; $display("FAIL full_contents: got %0d bad words want 0", bad); end
         checks++; if (wq_addr[4095] !== 12'hFFF || wq_data[4095] !== 16'hA5FF) begin
            errors++; $display("FAIL full_last: got %h/%h want FFF/A5FF", wq_addr[4095], wq_data[4095]);
         end
      end
      checks++; if (LOAD_DONE !== 1'b1 || CPU_HOLD !== 1'b0 || bus.MEM_ADDR !== 12'hFFF) begin
         errors++; $display("FAIL full_done: got done=%b hold=%b addr=%h want 1/0/FFF", LOAD_DONE, CPU_HOLD, bus.MEM_ADDR);
      end
   endtask

   task automatic test_stall();
      logic [7:0]  stream [8] = '{8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
      logic [15:0] exp_d  [3] = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
      clear_q();
      rdy_in_write = 0;
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(stream[i], 1);
      @(posedge clk); #1;
      checks++; if (wq_addr.size() !== 3) begin errors++; $display("FAIL stall_write_count: got %0d want 3", wq_addr.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (wq_addr[i] !== 12'(i) || wq_data[i] !== exp_d[i]) begin
               errors++; $display("FAIL stall_w%0d: got %h/%h want %h/%h", i, wq_addr[i], wq_data[i], 12'(i), exp_d[i]);
            end
         end
      end
      checks++; if (rdy_in_write !== 0) begin errors++; $display("FAIL stall_ready_in_write: got %0d cycles want 0", rdy_in_write); end
      checks++; if (LOAD_DONE !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", LOAD_DONE); end
   endtask

   task automatic test_mid_reset();
      int n_before;
      clear_q();
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h03, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      #2 reset = 1'b0;
      #1;
      checks++; if (bus.IN_READY !== 1'b0 || bus.MEM_WE !== 1'b0 || bus.MEM_ADDR !== 12'h000 || bus.MEM_DATA !== 16'h0000) begin
         errors++; $display("FAIL midrst_bus: got ready=%b we=%b addr=%h data=%h want 0/0/000/0000", bus.IN_READY, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_DATA);
      end
      checks++; if (CPU_HOLD !== 1'b1 || LOAD_DONE !== 1'b0 || LOAD_ERR !== 1'b0) begin
         errors++; $display("FAIL midrst_flags: got hold=%b done=%b err=%b want 1/0/0", CPU_HOLD, LOAD_DONE, LOAD_ERR);
      end
      n_before = wq_addr.size();
      checks++; if (n_before !== 1) begin errors++; $display("FAIL midrst_prior_writes: got %0d want 1", n_before); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      bus.IN_DATA = 8'h04;
      bus.IN_VALID = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.IN_VALID = 1'b0;
      checks++; if (wq_addr.size() !== n_before) begin errors++; $display("FAIL midrst_no_more_writes: got %0d want %0d", wq_addr.size(), n_before); end
      clear_q();
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h77, 0);
      send_byte(8'h88, 0);
      @(posedge clk); #1;
      checks++; if (wq_addr.size() !== 1 || wq_addr[0] !== 12'h000 || wq_data[0] !== 16'h7788) begin
         errors++; $display("FAIL midrst_reload: got n=%0d first addr/data=%h/%h want 1 000/7788", wq_addr.size(),
                            (wq_addr.size() > 0) ? wq_addr[0] : 12'hxxx, (wq_data.size() > 0) ? wq_data[0] : 16'hxxxx);
      end
      checks++; if (LOAD_DONE !== 1'b1 || CPU_HOLD !== 1'b0) begin
         errors++; $display("FAIL midrst_reload_done: got done=%b hold=%b want 1/0", LOAD_DONE, CPU_HOLD);
      end
   endtask

   initial begin
      START        = 1'b0;
      bus.IN_DATA  = '0;
      bus.IN_VALID = 1'b0;
      test_reset();
      test_basic();
      test_zero_len();
      test_error();
      test_full_memory();
      test_stall();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
